// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store engine with byte-lane alignment, req/ack handshake and timeout
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [2:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                stall,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [1:0]          resp_err,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);
    localparam int STRB  = DATA_W / 8;
    localparam int OFF_W = $clog2(STRB);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q;
    logic [15:0]         timer_q;
    logic                write_q;
    logic [2:0]          op_q;
    logic [OFF_W-1:0]    off_q;
    logic                mem_en_q;
    logic [STRB-1:0]     mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                resp_valid_q;
    logic [1:0]          resp_err_q;
    logic [DATA_W-1:0]   resp_rdata_q;

    logic [OFF_W-1:0]    req_off;
    logic [3:0]          req_nbytes;
    logic                op_legal;
    logic                op_aligned;
    logic [STRB-1:0]     size_strb;
    logic [STRB-1:0]     we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

    // Request decode: legality, alignment and lane placement of the incoming access
    always_comb begin
        req_off    = req_addr[OFF_W-1:0];
        req_nbytes = 4'd1 << req_op[1:0];
        op_legal   = 1'b0;
        if (req_write) begin
            op_legal = (req_op[2] == 1'b0) && ((req_op[1:0] != 2'b11) || (DATA_W == 64));
        end else begin
            case (req_op)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_legal = 1'b1;
                3'b011, 3'b110:                         op_legal = (DATA_W == 64);
                default:                                op_legal = 1'b0;
            endcase
        end
        op_aligned = (req_addr[2:0] & 3'(req_nbytes - 4'd1)) == 3'b000;
        size_strb  = STRB'((32'd1 << req_nbytes) - 32'd1);
        we_d       = req_write ? (size_strb << req_off) : '0;
        addr_d     = req_addr & ~ADDR_W'(STRB - 1);
        wdata_d    = '0;
        for (int i = 0; i < STRB; i++) begin
            wdata_d[8*i +: 8] = req_wdata[8*(i & (int'(req_nbytes) - 1)) +: 8];
        end
    end

    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   sign_src;
    logic [DATA_W-1:0]   ld_mask;
    logic [DATA_W-1:0]   ld_data;
    logic [3:0]          ld_nbytes;
    logic [6:0]          sign_pos;
    logic                ld_sign;

    // Load result: move the addressed lane to bit 0, then mask and extend to the access size
    always_comb begin
        shifted   = mem_rdata >> {off_q, 3'b000};
        ld_nbytes = 4'd1 << op_q[1:0];
        ld_mask   = ~({DATA_W{1'b1}} << {ld_nbytes, 3'b000});
        sign_pos  = {ld_nbytes, 3'b000} - 7'd1;
        sign_src  = shifted >> sign_pos;
        ld_sign   = ~op_q[2] & sign_src[0];
        ld_data   = (shifted & ld_mask) | (ld_sign ? ~ld_mask : '0);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            write_q      <= 1'b0;
            op_q         <= '0;
            off_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 2'b00;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        op_q    <= req_op;
                        off_q   <= req_off;
                        if (!op_legal || !op_aligned) begin
                            resp_err_q   <= !op_legal ? 2'b10 : 2'b01;
                            resp_rdata_q <= '0;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= we_d;
                            mem_addr_q  <= addr_d;
                            mem_wdata_q <= wdata_d;
                            timer_q     <= '0;
                            state_q     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // An ack arriving on the timeout cycle still completes the access
                    if (mem_ack) begin
                        mem_en_q     <= 1'b0;
                        mem_we_q     <= '0;
                        resp_err_q   <= 2'b00;
                        resp_rdata_q <= write_q ? '0 : ld_data;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else if (timer_q == 16'(TIMEOUT - 1)) begin
                        mem_en_q     <= 1'b0;
                        mem_we_q     <= '0;
                        resp_err_q   <= 2'b11;
                        resp_rdata_q <= '0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall      = ((state_q == IDLE) && req_valid) || (state_q == ACCESS);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
